// File: rtl/vid_axis_pkg.sv
// Shared constants and types for the AXI4-Stream video sink: default geometry,
// backpressure LFSR constants and the frame-tracking state encoding.
package vid_axis_pkg;

  localparam int unsigned DEF_H_ACTIVE = 1920;
  localparam int unsigned DEF_V_ACTIVE = 1080;
  localparam int unsigned DEF_DATA_W   = 24;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions of a right-shifting register.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  typedef enum logic {
    StIdle,
    StActive
  } vid_state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {^(cur & LFSR_TAP_MASK), cur[15:1]};
  endfunction

endpackage

// File: rtl/axis_bp_lfsr.sv
// Backpressure generator: free-running 16-bit Fibonacci LFSR and a registered
// ready that is held high when backpressure is disabled.
module axis_bp_lfsr
  import vid_axis_pkg::*;
(
  input  logic clk_in,
  input  logic reset,
  input  logic cfg_bp_en,
  output logic ready
);

  logic [15:0] lfsr_q;
  logic        started_q;
  logic        ready_q;
  logic        ready_d;

  // started_q holds ready low for one extra edge after reset release.
  always_comb begin
    ready_d = started_q & (~cfg_bp_en | lfsr_q[0] | lfsr_q[1]);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      lfsr_q    <= LFSR_SEED;
      started_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_step(lfsr_q);
      started_q <= 1'b1;
      ready_q   <= ready_d;
    end
  end

  assign ready = ready_q;

endmodule

// File: rtl/axis_video_sink.sv
// AXI4-Stream video sink and frame checker: tracks line/frame geometry,
// accumulates a per-frame checksum and raises sticky framing error flags.
module axis_video_sink
  import vid_axis_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned DATA_W   = DEF_DATA_W
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  input  logic              s_tuser,
  output logic              s_tready,
  input  logic              cfg_bp_en,
  input  logic              err_clr,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic [31:0]       frame_sum,
  output logic              err_early_eol,
  output logic              err_late_eol,
  output logic              err_sof
);

  localparam logic [15:0] HLen = 16'(H_ACTIVE);
  localparam logic [15:0] VLen = 16'(V_ACTIVE);

  vid_state_e  state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [31:0] sum_q, sum_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] frame_sum_q, frame_sum_d;
  logic        early_q, early_d;
  logic        late_q, late_d;
  logic        sof_q, sof_d;

  logic        ready;
  logic        xfer;
  logic [31:0] pix;
  logic        count_beat;
  logic [15:0] x_new;
  logic [15:0] y_base;
  logic [15:0] y_inc;
  logic [31:0] sum_new;
  logic        set_early, set_late, set_sof;

  axis_bp_lfsr u_bp (
    .clk_in    (clk_in),
    .reset     (reset),
    .cfg_bp_en (cfg_bp_en),
    .ready     (ready)
  );

  assign xfer = s_tvalid & ready;
  assign pix  = 32'(s_tdata);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    sum_d        = sum_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    frame_sum_d  = frame_sum_q;
    count_beat   = 1'b0;
    x_new        = x_q + 16'd1;
    y_base       = y_q;
    sum_new      = sum_q + pix;
    set_early    = 1'b0;
    set_late     = 1'b0;
    set_sof      = 1'b0;

    if (xfer) begin
      if (s_tuser) begin
        // A tuser inside a frame drops the partial frame and restarts here.
        set_sof    = (state_q == StActive);
        count_beat = 1'b1;
        x_new      = 16'd1;
        y_base     = 16'd0;
        sum_new    = pix;
      end else if (state_q == StIdle) begin
        set_sof = 1'b1;
      end else begin
        count_beat = 1'b1;
      end
    end

    y_inc = y_base + 16'd1;

    if (count_beat) begin
      state_d   = StActive;
      x_d       = x_new;
      y_d       = y_base;
      sum_d     = sum_new;
      set_early = s_tlast && (x_new < HLen);
      set_late  = !s_tlast && (x_new == HLen);
      if (s_tlast || (x_new == HLen)) begin
        x_d = 16'd0;
        y_d = y_inc;
        if (y_inc == VLen) begin
          state_d      = StIdle;
          y_d          = 16'd0;
          frame_done_d = 1'b1;
          frame_sum_d  = sum_new;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end
      end
    end

    // A new error in the same cycle as err_clr wins.
    early_d = (early_q & ~err_clr) | set_early;
    late_d  = (late_q & ~err_clr) | set_late;
    sof_d   = (sof_q & ~err_clr) | set_sof;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      x_q          <= 16'd0;
      y_q          <= 16'd0;
      sum_q        <= 32'd0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
      frame_sum_q  <= 32'd0;
      early_q      <= 1'b0;
      late_q       <= 1'b0;
      sof_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sum_q        <= sum_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_sum_q  <= frame_sum_d;
      early_q      <= early_d;
      late_q       <= late_d;
      sof_q        <= sof_d;
    end
  end

  assign s_tready      = ready;
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;
  assign frame_sum     = frame_sum_q;
  assign err_early_eol = early_q;
  assign err_late_eol  = late_q;
  assign err_sof       = sof_q;

endmodule

// File: tb/tb_axis_video_sink.sv
// Directed bench for axis_video_sink with a 4x3 frame geometry.
module tb_axis_video_sink;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic        s_tready;
  logic        cfg_bp_en = 1'b0;
  logic        err_clr = 1'b0;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [31:0] frame_sum;
  logic        err_early_eol;
  logic        err_late_eol;
  logic        err_sof;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int base;
  int lows;

  axis_video_sink #(
    .H_ACTIVE (4),
    .V_ACTIVE (3),
    .DATA_W   (24)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tlast       (s_tlast),
    .s_tuser       (s_tuser),
    .s_tready      (s_tready),
    .cfg_bp_en     (cfg_bp_en),
    .err_clr       (err_clr),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt),
    .frame_sum     (frame_sum),
    .err_early_eol (err_early_eol),
    .err_late_eol  (err_late_eol),
    .err_sof       (err_sof)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic beat(input int d, input logic u, input logic l);
    int n;
    s_tdata  = 24'(d);
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    n = 0;
    while (s_tready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("ready_timeout", 32'(n), 32'd0);
    tick();
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic frame12();
    for (int i = 1; i <= 12; i++) beat(i, i == 1, (i % 4) == 0);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_frame_sum", frame_sum, 32'd0);
    chk("rst_errs", {29'd0, err_early_eol, err_late_eol, err_sof}, 32'd0);
    reset = 1'b0;
    tick();
    chk("tready_edge1", 32'(s_tready), 32'd0);
    tick();
    chk("tready_edge2", 32'(s_tready), 32'd1);

    // Data before the first tuser is discarded and flagged
    beat(5, 1'b0, 1'b1);
    chk("pre_sof_err", 32'(err_sof), 32'd1);
    chk("pre_sof_no_eol", 32'(err_early_eol), 32'd0);
    clear_errs();
    chk("sof_cleared", 32'(err_sof), 32'd0);
    err_clr = 1'b1;
    beat(6, 1'b0, 1'b0);
    err_clr = 1'b0;
    chk("set_beats_clr", 32'(err_sof), 32'd1);
    clear_errs();

    // Clean frame, no backpressure
    base = done_cnt;
    frame12();
    chk("t1_done", 32'(frame_done), 32'd1);
    chk("t1_sum", frame_sum, 32'd78);
    chk("t1_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_errs", {29'd0, err_early_eol, err_late_eol, err_sof}, 32'd0);
    tick();
    chk("t1_done_pulse", 32'(frame_done), 32'd0);
    chk("t1_done_count", 32'(done_cnt - base), 32'd1);

    // Same frame under backpressure
    cfg_bp_en = 1'b1;
    base = done_cnt;
    frame12();
    chk("t2_sum", frame_sum, 32'd78);
    chk("t2_cnt", 32'(frame_cnt), 32'd2);
    tick();
    chk("t2_done_count", 32'(done_cnt - base), 32'd1);
    chk("t2_errs", {29'd0, err_early_eol, err_late_eol, err_sof}, 32'd0);
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (s_tready !== 1'b1) lows++;
    end
    chk("t2_bp_duty", 32'(lows >= 200), 32'd1);
    cfg_bp_en = 1'b0;
    repeat (2) tick();

    // Early end of line in line 0
    base = done_cnt;
    for (int i = 1; i <= 11; i++) begin
      beat(i, i == 1, i == 3 || i == 7 || i == 11);
      if (i == 3) chk("t3_early_set", 32'(err_early_eol), 32'd1);
    end
    chk("t3_done", 32'(frame_done), 32'd1);
    chk("t3_sum", frame_sum, 32'd66);
    chk("t3_cnt", 32'(frame_cnt), 32'd3);
    tick();
    chk("t3_done_count", 32'(done_cnt - base), 32'd1);
    clear_errs();

    // Line 1 without tlast; 5th beat becomes pixel 1 of line 2
    base = done_cnt;
    for (int i = 1; i <= 12; i++) begin
      beat(i, i == 1, i == 4 || i == 12);
      if (i == 8) chk("t4_late_set", 32'(err_late_eol), 32'd1);
    end
    chk("t4_done", 32'(frame_done), 32'd1);
    chk("t4_sum", frame_sum, 32'd78);
    chk("t4_cnt", 32'(frame_cnt), 32'd4);
    chk("t4_no_early", 32'(err_early_eol), 32'd0);
    tick();
    chk("t4_done_count", 32'(done_cnt - base), 32'd1);
    clear_errs();

    // tuser reasserted on beat 6 restarts the frame
    base = done_cnt;
    for (int i = 1; i <= 5; i++) beat(i, i == 1, i == 4);
    for (int i = 1; i <= 12; i++) begin
      beat(i, i == 1, (i % 4) == 0);
      if (i == 1) chk("t5_sof_set", 32'(err_sof), 32'd1);
      if (i == 11) chk("t5_no_done_yet", 32'(done_cnt - base), 32'd0);
    end
    chk("t5_done", 32'(frame_done), 32'd1);
    chk("t5_sum", frame_sum, 32'd78);
    chk("t5_cnt", 32'(frame_cnt), 32'd5);
    tick();
    chk("t5_done_count", 32'(done_cnt - base), 32'd1);
    clear_errs();

    // Reset mid-frame, then a clean frame
    for (int i = 1; i <= 7; i++) beat(i, i == 1, i == 2);
    chk("t6_early_pre_rst", 32'(err_early_eol), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_tready", 32'(s_tready), 32'd0);
    chk("t6_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("t6_rst_sum", frame_sum, 32'd0);
    chk("t6_rst_done", 32'(frame_done), 32'd0);
    chk("t6_rst_errs", {29'd0, err_early_eol, err_late_eol, err_sof}, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    base = done_cnt;
    frame12();
    chk("t6_done", 32'(frame_done), 32'd1);
    chk("t6_cnt", 32'(frame_cnt), 32'd1);
    chk("t6_sum", frame_sum, 32'd78);
    chk("t6_errs", {29'd0, err_early_eol, err_late_eol, err_sof}, 32'd0);
    tick();
    chk("t6_done_count", 32'(done_cnt - base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_video_sink.md
# axis_video_sink

AXI4-Stream video sink and frame checker: the receiving end of the team's 24-bit RGB video stream (tuser = start of frame, tlast = end of line). Drives tready, optionally with pseudo-random backpressure. Checks line length and frame height against the configured geometry, and reports per-frame counts, a pixel checksum and sticky error flags. Used in simulation benches and as a synthesizable on-chip monitor.

## Interface
Parameters:
- H_ACTIVE, 1920: pixels per line.
- V_ACTIVE, 1080: lines per frame.
- DATA_W, 24: tdata width.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_tdata  in  DATA_W  pixel data.
- s_tvalid  in  1  beat valid.
- s_tlast  in  1  end of line.
- s_tuser  in  1  start of frame (first pixel).
- s_tready  out  1  sink ready; registered.
- cfg_bp_en  in  1  1 = pseudo-random backpressure, 0 = tready held high.
- err_clr  in  1  single-cycle pulse; clears sticky error flags.
- frame_done  out  1  one-cycle pulse; a complete V_ACTIVE-line frame was accepted.
- frame_cnt  out  16  completed frames, wraps at 0xFFFF→0.
- frame_sum  out  32  checksum of the last completed frame.
- err_early_eol  out  1  sticky; tlast before H_ACTIVE pixels.
- err_late_eol  out  1  sticky; H_ACTIVE pixels with no tlast.
- err_sof  out  1  sticky; tuser inside a frame, or data before the first tuser.

## Operation
- A transfer is a cycle with s_tvalid & s_tready. Nothing happens on cycles without a transfer.
- Counters:
  - x_cnt: 16 bit, pixel in line.
  - y_cnt: 16 bit, line in frame.
  - sum_acc: 32 bit, running checksum; adds zero-extended s_tdata on each counted transfer, modulo 2^32.
- State IDLE (wait for start of frame):
  - Transfer with tuser=0: discarded and sets err_sof.
  - Transfer with tuser=1: go to ACTIVE. Set x_cnt=1, y_cnt=0, sum_acc=tdata.
  - The line-end rules below also apply to this first beat.
- State ACTIVE, counted transfer:
  - tuser=1: set err_sof. The partial frame is dropped with no frame_done. Restart as for IDLE with tuser=1.
  - Otherwise x_cnt+1 and sum_acc+tdata.
- Line end happens at the first of:
  - tlast, with new x_cnt < H_ACTIVE: set err_early_eol.
  - new x_cnt == H_ACTIVE: set err_late_eol if tlast=0.
  - At line end: x_cnt←0, y_cnt+1. The next beat starts a new line. Any later stray tlast-less beats are counted into that next line.
- When the line end makes y_cnt reach V_ACTIVE:
  - frame_done pulses.
  - frame_sum←final sum_acc.
  - frame_cnt+1.
  - Return to IDLE.
- Sticky flags are cleared by err_clr. If err_clr and a new error fall in the same cycle, the set wins.
- Backpressure: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1) advances every cycle out of reset.
  - Next-cycle s_tready = ~cfg_bp_en | lfsr[0] | lfsr[1] (about 75% duty).
  - s_tready never depends on s_tvalid.

## Timing
- Reset values: s_tready=0, frame_done=0, frame_cnt=0, frame_sum=0, all err_*=0, state IDLE, LFSR=seed.
- s_tready first rises on the second rising edge after reset deasserts. Reset is asynchronous and aborts any frame in progress.
- Counters and sum_acc update on the edge that completes the transfer.
- frame_done, frame_sum, frame_cnt and err_* become valid in the cycle after the accepting edge (1-cycle latency, registered).
- cfg_bp_en changes take effect on the next s_tready update. A transfer already in flight is unaffected.
- Back-to-back frames: a tuser beat in the cycle right after the frame-closing beat is accepted as a normal start of frame.

## Structure
- Package vid_axis_pkg holds:
  - default H_ACTIVE / V_ACTIVE / DATA_W;
  - LFSR seed and tap constants;
  - the IDLE/ACTIVE state encoding.
- Sub-module axis_bp_lfsr: LFSR plus registered ready generation. Inputs clk_in, reset, cfg_bp_en; output ready.
- Top level holds the state machine, counters, checksum and flags. Expected size is about 200 lines.

## Test plan
Default geometry for all cases: H_ACTIVE=4, V_ACTIVE=3, DATA_W=24.
- Clean frame, cfg_bp_en=0: 12 beats with tdata=1..12, tuser on beat 1, tlast on beats 4/8/12 → one frame_done pulse, frame_sum=78, frame_cnt=1, all err_*=0.
- Same frame with cfg_bp_en=1 and tvalid held high → identical frame_sum=78. No beat is lost or duplicated. s_tready low on at least 20% of cycles over 1000 cycles.
- tlast on the 3rd pixel of line 0 → err_early_eol=1. Frame completes after 11 beats total; frame_done pulses.
- Line 1 sent with no tlast (5 beats before tlast) → err_late_eol=1. The 5th beat is counted as pixel 1 of line 2.
- tuser reasserted on beat 6 → err_sof=1. No frame_done for the first frame. frame_done fires 12 beats after beat 6.
- Reset asserted mid-frame (after beat 7), then released → all outputs return to reset values. A subsequent clean frame gives frame_cnt=1, frame_sum=78.
